cnn_frame_feeder: RTL

- Upstream stage of the CNN digit-recognition top level. Buffers one 28x28 8-bit image received over a valid/ready stream.
- Holds the CNN in reset while loading. Releases it and drives one pixel per clock on the CNN's `data_in`.
- Waits for the CNN's `finish` pulse, then returns `decision` to the host through a valid/ready result port.
- Single frame buffer: loading and inference do not overlap.

---
 rtl/cnn_frame_feeder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cnn_frame_feeder.sv
// rtl/cnn_frame_feeder.sv - frame buffer and sequencer feeding one 28x28 image into the CNN core
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_valid, s_ready, s_data    host pixel stream, row-major, pixel 0 first
//   cnn_rst_n, cnn_data         registered drive of the CNN core reset and pixel input
//   cnn_decision, cnn_finish    CNN core result and single-cycle completion pulse
//   res_valid, res_ready        result handshake to the host
//   res_decision, res_timeout   classified digit (4'hF on timeout) and timeout flag
//   busy                        low only while the frame buffer is accepting pixels
module cnn_frame_feeder #(
    parameter int IMG_PIXELS = 784,
    parameter int DATA_BITS  = 8,
    parameter int ADDR_BITS  = 10,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 cnn_rst_n,
    output logic [DATA_BITS-1:0] cnn_data,
    input  logic [3:0]           cnn_decision,
    input  logic                 cnn_finish,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [3:0]           res_decision,
    output logic                 res_timeout,
    output logic                 busy
);
    localparam int TO_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_BITS-1:0] LAST_PIX  = ADDR_BITS'(IMG_PIXELS - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ARM  = ADDR_BITS'(RST_CYCLES - 1);
    localparam logic [TO_BITS-1:0]   LAST_WAIT = TO_BITS'(TIMEOUT - 1);

    // ST_IDLE only exists for the single cycle between reset release and the
    // first clock, so every status output can read back as zero during reset.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_STREAM,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [ADDR_BITS-1:0] cnt;
    logic [TO_BITS-1:0]   to_cnt;
    logic [DATA_BITS-1:0] mem [IMG_PIXELS];
    logic                 wr_en;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 wait_expired;

    // cnt is the write address in LOAD, the hold-off count in ARM and the
    // pixel index in STREAM; it restarts from zero on every state change.
    assign wr_en        = (state == ST_LOAD) && s_valid && s_ready;
    assign wait_expired = (to_cnt == LAST_WAIT);

    // Reads run one cycle ahead of the pixel shown on cnn_data: the last ARM
    // cycle fetches pixel 0, and STREAM pixel k fetches pixel k+1.
    assign rd_en   = ((state == ST_ARM) && (cnt == LAST_ARM)) ||
                     ((state == ST_STREAM) && (cnt != LAST_PIX));
    assign rd_addr = (state == ST_STREAM) ? cnt + ADDR_BITS'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   next_state = ST_LOAD;
            ST_LOAD:   if (wr_en && (cnt == LAST_PIX)) next_state = ST_ARM;
            ST_ARM:    if (cnt == LAST_ARM) next_state = ST_STREAM;
            ST_STREAM: if (cnt == LAST_PIX) next_state = ST_WAIT;
            ST_WAIT:   if (cnn_finish || wait_expired) next_state = ST_RESULT;
            ST_RESULT: if (res_ready) next_state = ST_LOAD;
            default:   next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (wr_en || (state == ST_ARM) || (state == ST_STREAM)) begin
            cnt <= cnt + ADDR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT) begin
            to_cnt <= to_cnt + TO_BITS'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // Frame buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt] <= s_data;
        end
    end

    // Registered read port doubles as the cnn_data output register, forced
    // to zero whenever no pixel is being streamed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnn_data <= '0;
        end else if (rd_en) begin
            cnn_data <= mem[rd_addr];
        end else begin
            cnn_data <= '0;
        end
    end

    // Status outputs are registered copies of the state being entered, so
    // they line up with the state itself without any combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            cnn_rst_n <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            s_ready   <= (next_state == ST_LOAD);
            busy      <= (next_state != ST_LOAD);
            cnn_rst_n <= (next_state == ST_STREAM) || (next_state == ST_WAIT) ||
                         (next_state == ST_RESULT);
            res_valid <= (next_state == ST_RESULT);
        end
    end

    // A finish in the final timeout cycle still reports the real decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_decision <= 4'h0;
            res_timeout  <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (cnn_finish) begin
                res_decision <= cnn_decision;
                res_timeout  <= 1'b0;
            end else if (wait_expired) begin
                res_decision <= 4'hF;
                res_timeout  <= 1'b1;
            end
        end
    end

endmodule
